// File: rtl/udp_audio_packetizer.sv
// UDP audio packetizer: buffers 16-bit samples in a FIFO and emits packets
// of {seq_hi, seq_lo, sample bytes big-endian} over a header/byte handshake.
module udp_audio_packetizer #(
  parameter int unsigned SAMPLES_PER_PKT = 256,
  parameter int unsigned FIFO_DEPTH      = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic        i_sample_valid,
  input  logic [15:0] i_sample,
  output logic        udp_tx_hdr_valid,
  input  logic        udp_tx_hdr_ready,
  output logic        udp_tx_valid,
  input  logic        udp_tx_ready,
  output logic        udp_tx_last,
  output logic [7:0]  udp_tx_data,
  output logic [15:0] o_tx_length,
  output logic        o_overflow,
  output logic [15:0] o_pkt_count
);

  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned IDX_W   = (SAMPLES_PER_PKT > 1) ? $clog2(SAMPLES_PER_PKT) : 1;
  localparam int unsigned PAY_LEN = 2 + 2 * SAMPLES_PER_PKT;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_SEQ_HI, S_SEQ_LO, S_DATA_HI, S_DATA_LO
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      seq_q;
  logic [15:0]      head;
  logic             full, byte_acc, pop, pkt_done, wr_en, drop;
  logic             hdr_valid_d, valid_d, last_d;
  logic [7:0]       data_d;

  assign o_tx_length = 16'(PAY_LEN);

  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign byte_acc = udp_tx_valid && udp_tx_ready;
  assign pop      = (state_q == S_DATA_LO) && byte_acc;
  assign pkt_done = pop && (idx_q == IDX_W'(SAMPLES_PER_PKT - 1));
  assign wr_en    = i_sample_valid && i_enable && (!full || pop);
  assign drop     = i_sample_valid && i_enable && full && !pop;

  // Prefetch: look at the head the FIFO will have after this edge's pop
  assign rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
  assign head     = mem[rd_ptr_d];

  // Sample storage (no reset needed, validity tracked by pointers)
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr_q] <= i_sample;
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hdr_valid_d = 1'b0;
    valid_d     = 1'b0;
    last_d      = 1'b0;
    data_d      = 8'h00;
    case (state_q)
      S_IDLE:    if (count_q >= CNT_W'(SAMPLES_PER_PKT)) state_d = S_HDR;
      S_HDR:     if (udp_tx_hdr_valid && udp_tx_hdr_ready) state_d = S_SEQ_HI;
      S_SEQ_HI:  if (byte_acc) state_d = S_SEQ_LO;
      S_SEQ_LO:  if (byte_acc) begin
                   state_d = S_DATA_HI;
                   idx_d   = '0;
                 end
      S_DATA_HI: if (byte_acc) state_d = S_DATA_LO;
      S_DATA_LO: if (byte_acc) begin
                   if (pkt_done) begin
                     state_d = S_IDLE;
                   end else begin
                     state_d = S_DATA_HI;
                     idx_d   = idx_q + IDX_W'(1);
                   end
                 end
      default:   state_d = S_IDLE;
    endcase
    case (state_d)
      S_HDR:     hdr_valid_d = 1'b1;
      S_SEQ_HI:  begin valid_d = 1'b1; data_d = seq_q[15:8]; end
      S_SEQ_LO:  begin valid_d = 1'b1; data_d = seq_q[7:0]; end
      S_DATA_HI: begin valid_d = 1'b1; data_d = head[15:8]; end
      S_DATA_LO: begin
                   valid_d = 1'b1;
                   data_d  = head[7:0];
                   last_d  = (idx_d == IDX_W'(SAMPLES_PER_PKT - 1));
                 end
      default:   ;
    endcase
  end

  // State, FIFO bookkeeping, counters and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q          <= S_IDLE;
      idx_q            <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      seq_q            <= 16'h0000;
      o_pkt_count      <= 16'h0000;
      o_overflow       <= 1'b0;
      udp_tx_hdr_valid <= 1'b0;
      udp_tx_valid     <= 1'b0;
      udp_tx_last      <= 1'b0;
      udp_tx_data      <= 8'h00;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      rd_ptr_q         <= rd_ptr_d;
      udp_tx_hdr_valid <= hdr_valid_d;
      udp_tx_valid     <= valid_d;
      udp_tx_last      <= last_d;
      udp_tx_data      <= data_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (wr_en && !pop)      count_q <= count_q + CNT_W'(1);
      else if (!wr_en && pop) count_q <= count_q - CNT_W'(1);
      if (drop) o_overflow <= 1'b1;
      if (pkt_done) begin
        seq_q       <= seq_q + 16'd1;
        o_pkt_count <= o_pkt_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_udp_audio_packetizer.sv
// Directed self-checking bench for udp_audio_packetizer (4 samples/packet, 8-deep FIFO).
module tb_udp_audio_packetizer;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_enable = 1'b1;
  logic        i_sample_valid = 1'b0;
  logic [15:0] i_sample = 16'h0000;
  logic        udp_tx_hdr_valid;
  logic        udp_tx_hdr_ready = 1'b0;
  logic        udp_tx_valid;
  logic        udp_tx_ready = 1'b0;
  logic        udp_tx_last;
  logic [7:0]  udp_tx_data;
  logic [15:0] o_tx_length;
  logic        o_overflow;
  logic [15:0] o_pkt_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_b [10];

  udp_audio_packetizer #(.SAMPLES_PER_PKT(4), .FIFO_DEPTH(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable),
    .i_sample_valid(i_sample_valid), .i_sample(i_sample),
    .udp_tx_hdr_valid(udp_tx_hdr_valid), .udp_tx_hdr_ready(udp_tx_hdr_ready),
    .udp_tx_valid(udp_tx_valid), .udp_tx_ready(udp_tx_ready),
    .udp_tx_last(udp_tx_last), .udp_tx_data(udp_tx_data),
    .o_tx_length(o_tx_length), .o_overflow(o_overflow), .o_pkt_count(o_pkt_count)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

  task automatic write_sample(input logic [15:0] s, input bit en);
    i_enable       = en;
    i_sample_valid = 1'b1;
    i_sample       = s;
    tick();
    i_sample_valid = 1'b0;
    i_enable       = 1'b1;
  endtask

  task automatic set_exp(input logic [15:0] seq, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
    exp_b[0] = seq[15:8]; exp_b[1] = seq[7:0];
    exp_b[2] = a[15:8];   exp_b[3] = a[7:0];
    exp_b[4] = b[15:8];   exp_b[5] = b[7:0];
    exp_b[6] = c[15:8];   exp_b[7] = c[7:0];
    exp_b[8] = d[15:8];   exp_b[9] = d[7:0];
  endtask

  // Receive one packet and compare it against exp_b; optionally write a sample
  // in the same cycle the byte with index wr_at is accepted.
  task automatic recv_packet(input bit rnd, input int hdr_delay, input bit gapless,
                             input int wr_at, input logic [15:0] wr_val);
    int         cyc;
    int         nb;
    bit         stalled;
    bit         wr_pending;
    logic [7:0] pd;
    logic       pl;
    udp_tx_ready     = 1'b0;
    udp_tx_hdr_ready = 1'b0;
    cyc = 0;
    while (!udp_tx_hdr_valid && cyc < 200) begin
      tick();
      cyc++;
    end
    check("hdr_seen", udp_tx_hdr_valid, 1);
    for (int i = 0; i < hdr_delay; i++) begin
      tick();
      check("hdr_held", udp_tx_hdr_valid, 1);
      check("no_valid_before_hdr", udp_tx_valid, 0);
    end
    udp_tx_hdr_ready = 1'b1;
    tick();
    udp_tx_hdr_ready = 1'b0;
    check("hdr_dropped", udp_tx_hdr_valid, 0);
    nb = 0; cyc = 0; stalled = 1'b0; wr_pending = 1'b0; pd = 8'h00; pl = 1'b0;
    while (nb < 10 && cyc < 400) begin
      if (stalled) begin
        check("valid_held", udp_tx_valid, 1);
        check("data_stable", udp_tx_data, pd);
        check("last_stable", udp_tx_last, pl);
      end
      if (udp_tx_valid) begin
        udp_tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (udp_tx_ready) begin
          check($sformatf("byte%0d", nb), udp_tx_data, exp_b[nb]);
          check($sformatf("last%0d", nb), udp_tx_last, (nb == 9));
          if (nb == wr_at) begin
            i_sample_valid = 1'b1;
            i_sample       = wr_val;
            wr_pending     = 1'b1;
          end
          nb++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          pd      = udp_tx_data;
          pl      = udp_tx_last;
        end
      end else if (gapless) begin
        check("payload_gap", udp_tx_valid, 1);
      end
      tick();
      if (wr_pending) begin
        i_sample_valid = 1'b0;
        wr_pending     = 1'b0;
      end
      cyc++;
    end
    udp_tx_ready = 1'b0;
    check("pkt_bytes", nb, 10);
    check("valid_low_after_last", udp_tx_valid, 0);
  endtask

  initial begin
    // Reset state
    tick();
    do_reset();
    check("rst_hdr_valid", udp_tx_hdr_valid, 0);
    check("rst_valid", udp_tx_valid, 0);
    check("rst_last", udp_tx_last, 0);
    check("rst_data", udp_tx_data, 8'h00);
    check("rst_overflow", o_overflow, 0);
    check("rst_pkt_count", o_pkt_count, 16'h0000);
    check("tx_length", o_tx_length, 16'd10);

    // 1: basic packet and header latency
    write_sample(16'h1234, 1'b1);
    write_sample(16'h5678, 1'b1);
    write_sample(16'h9ABC, 1'b1);
    check("t1_no_hdr_early", udp_tx_hdr_valid, 0);
    write_sample(16'hDEF0, 1'b1);
    check("t1_hdr_not_yet", udp_tx_hdr_valid, 0);
    tick();
    check("t1_hdr_k_plus_1", udp_tx_hdr_valid, 1);
    set_exp(16'h0000, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    recv_packet(1'b0, 0, 1'b1, -1, 16'h0000);
    check("t1_pkt_count", o_pkt_count, 16'd1);
    check("t1_tx_length", o_tx_length, 16'd10);

    // 2: backpressure, delayed header accept
    do_reset();
    write_sample(16'h1234, 1'b1);
    write_sample(16'h5678, 1'b1);
    write_sample(16'h9ABC, 1'b1);
    write_sample(16'hDEF0, 1'b1);
    recv_packet(1'b1, 5, 1'b0, -1, 16'h0000);
    check("t2_pkt_count", o_pkt_count, 16'd1);

    // 3: overflow with header held off
    do_reset();
    for (int i = 1; i <= 8; i++) write_sample(16'(i), 1'b1);
    check("t3_no_overflow_at_8", o_overflow, 0);
    write_sample(16'h0009, 1'b1);
    check("t3_overflow_at_9", o_overflow, 1);
    write_sample(16'h000A, 1'b1);
    set_exp(16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    recv_packet(1'b0, 0, 1'b1, -1, 16'h0000);
    set_exp(16'h0001, 16'h0005, 16'h0006, 16'h0007, 16'h0008);
    recv_packet(1'b0, 0, 1'b1, -1, 16'h0000);
    check("t3_overflow_sticky", o_overflow, 1);
    check("t3_pkt_count", o_pkt_count, 16'd2);
    repeat (4) tick();
    check("t3_no_third_pkt", udp_tx_hdr_valid, 0);

    // 4: back-to-back packets with a concurrent sample stream
    do_reset();
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          write_sample(16'h1000 + 16'(i), 1'b1);
          tick();
          tick();
        end
      end
      begin
        for (int p = 0; p < 3; p++) begin
          set_exp(16'(p), 16'h1000 + 16'(4*p), 16'h1001 + 16'(4*p),
                  16'h1002 + 16'(4*p), 16'h1003 + 16'(4*p));
          recv_packet(1'b0, 0, 1'b1, -1, 16'h0000);
        end
      end
    join
    check("t4_pkt_count", o_pkt_count, 16'd3);
    check("t4_no_overflow", o_overflow, 0);

    // 5: reset after the third payload byte
    do_reset();
    for (int i = 0; i < 4; i++) write_sample(16'hA0A0 + 16'(i), 1'b1);
    while (!udp_tx_hdr_valid) tick();
    udp_tx_hdr_ready = 1'b1;
    tick();
    udp_tx_hdr_ready = 1'b0;
    udp_tx_ready     = 1'b1;
    repeat (3) tick();
    udp_tx_ready = 1'b0;
    i_rst        = 1'b1;
    tick();
    i_rst = 1'b0;
    check("t5_hdr_valid", udp_tx_hdr_valid, 0);
    check("t5_valid", udp_tx_valid, 0);
    check("t5_last", udp_tx_last, 0);
    check("t5_data", udp_tx_data, 8'h00);
    check("t5_pkt_count", o_pkt_count, 16'h0000);
    check("t5_overflow", o_overflow, 0);
    write_sample(16'hFFFF, 1'b0);
    for (int i = 0; i < 3; i++) write_sample(16'hC000 + 16'(i), 1'b1);
    repeat (3) tick();
    check("t5_no_hdr_3_fresh", udp_tx_hdr_valid, 0);
    write_sample(16'hC003, 1'b1);
    set_exp(16'h0000, 16'hC000, 16'hC001, 16'hC002, 16'hC003);
    recv_packet(1'b0, 0, 1'b1, -1, 16'h0000);

    // 6: write accepted while full in the same cycle as a pop
    do_reset();
    for (int i = 1; i <= 8; i++) write_sample(16'h0B00 + 16'(i), 1'b1);
    set_exp(16'h0000, 16'h0B01, 16'h0B02, 16'h0B03, 16'h0B04);
    recv_packet(1'b0, 0, 1'b1, 3, 16'h0B09);
    check("t6_no_overflow", o_overflow, 0);
    set_exp(16'h0001, 16'h0B05, 16'h0B06, 16'h0B07, 16'h0B08);
    recv_packet(1'b0, 0, 1'b1, -1, 16'h0000);
    write_sample(16'h0B0A, 1'b1);
    write_sample(16'h0B0B, 1'b1);
    write_sample(16'h0B0C, 1'b1);
    set_exp(16'h0002, 16'h0B09, 16'h0B0A, 16'h0B0B, 16'h0B0C);
    recv_packet(1'b0, 0, 1'b1, -1, 16'h0000);
    check("t6_overflow_final", o_overflow, 0);
    check("t6_pkt_count", o_pkt_count, 16'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
